// File: rtl/icache_data_array.sv
// icache_data_array: multi-way instruction-cache data store with a one-cycle read port
// and a wrapped, critical-word-first line refill engine.
module icache_data_array #(
    parameter int WAYS       = 2,
    parameter int INDEX_W    = 7,
    parameter int LINE_WORDS = 8,
    parameter int DATA_W     = 32,
    localparam int OFF_W     = $clog2(LINE_WORDS),
    localparam int WAY_W     = WAYS > 1 ? $clog2(WAYS) : 1
) (
    input  logic               clk_i,
    input  logic               resetn_i,
    input  logic               rd_en_i,
    output logic               rd_ready_o,
    input  logic [INDEX_W-1:0] rd_index_i,
    input  logic [OFF_W-1:0]   rd_offset_i,
    input  logic [WAYS-1:0]    rd_hit_way_i,
    output logic               rd_valid_o,
    output logic [DATA_W-1:0]  rd_data_o,
    input  logic               refill_start_i,
    input  logic [WAY_W-1:0]   refill_way_i,
    input  logic [INDEX_W-1:0] refill_index_i,
    input  logic [OFF_W-1:0]   refill_offset_i,
    input  logic               refill_valid_i,
    input  logic [DATA_W-1:0]  refill_data_i,
    input  logic               refill_last_i,
    output logic               refill_busy_o,
    output logic               refill_done_o,
    output logic               refill_err_o
);
    localparam int SETS = 1 << INDEX_W;
    localparam logic [OFF_W:0] CNT_FULL = (OFF_W+1)'(LINE_WORDS);
    localparam logic [OFF_W:0] CNT_LAST = (OFF_W+1)'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t             state_q, state_d;
    logic [WAY_W-1:0]   way_q, way_d;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic [OFF_W-1:0]   ptr_q, ptr_d;
    logic [OFF_W:0]     cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               wr_en, rd_acc, rd_valid_q;
    logic [WAYS-1:0]    hit_q;
    logic [DATA_W-1:0]  masked [WAYS];

    assign refill_busy_o = state_q != IDLE;
    assign refill_done_o = state_q == DONE;
    assign refill_err_o  = refill_done_o && err_q;
    assign rd_ready_o    = !(refill_busy_o && rd_index_i == idx_q);
    assign rd_acc        = rd_en_i && rd_ready_o;
    assign rd_valid_o    = rd_valid_q;

    always_comb begin
        state_d = state_q;
        way_d   = way_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: if (refill_start_i) begin
                state_d = FILL;
                way_d   = refill_way_i;
                idx_d   = refill_index_i;
                ptr_d   = refill_offset_i;
                cnt_d   = '0;
            end
            FILL: if (refill_valid_i) begin
                wr_en = cnt_q != CNT_FULL;
                ptr_d = wr_en ? ptr_q + 1'b1 : ptr_q;
                cnt_d = wr_en ? cnt_q + 1'b1 : cnt_q;
                // a saturated count at the last beat means the line overran
                if (refill_last_i) begin
                    state_d = DONE;
                    err_d   = cnt_q != CNT_LAST;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= IDLE;
            way_q      <= '0;
            idx_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            hit_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            way_q      <= way_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rd_valid_q <= rd_acc;
            if (rd_acc) hit_q <= rd_hit_way_i;
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [DATA_W-1:0] mem [SETS*LINE_WORDS];
        logic [DATA_W-1:0] q;
        always_ff @(posedge clk_i) begin
            if (wr_en && way_q == WAY_W'(w)) mem[{idx_q, ptr_q}] <= refill_data_i;
            if (rd_acc) q <= mem[{rd_index_i, rd_offset_i}];
        end
        assign masked[w] = hit_q[w] ? q : '0;
    end

    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < WAYS; i++) rd_data_o = rd_data_o | masked[i];
    end
endmodule

// File: tb/tb_icache_data_array.sv
// tb_icache_data_array: directed refill/read scenarios checked every cycle against a
// line-level behavioural model, plus literal spot checks.
module tb_icache_data_array;
    logic        clk = 0;
    logic        resetn = 0;
    logic        rd_en = 0, rd_ready, rd_valid;
    logic [6:0]  rd_index = 0;
    logic [2:0]  rd_offset = 0;
    logic [1:0]  rd_hit_way = 0;
    logic [31:0] rd_data;
    logic        refill_start = 0, refill_way = 0, refill_valid = 0, refill_last = 0;
    logic [6:0]  refill_index = 0;
    logic [2:0]  refill_offset = 0;
    logic [31:0] refill_data = 0;
    logic        refill_busy, refill_done, refill_err;

    int n_tot = 0, n_pass = 0;
    bit started = 0;

    icache_data_array dut (
        .clk_i(clk), .resetn_i(resetn),
        .rd_en_i(rd_en), .rd_ready_o(rd_ready), .rd_index_i(rd_index),
        .rd_offset_i(rd_offset), .rd_hit_way_i(rd_hit_way),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .refill_start_i(refill_start), .refill_way_i(refill_way),
        .refill_index_i(refill_index), .refill_offset_i(refill_offset),
        .refill_valid_i(refill_valid), .refill_data_i(refill_data),
        .refill_last_i(refill_last), .refill_busy_o(refill_busy),
        .refill_done_o(refill_done), .refill_err_o(refill_err)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    // Model: line contents per way/set, refill phase 0 idle / 1 filling / 2 done.
    logic [31:0] m_mem [2][128][8];
    bit          m_known [2][128][8];
    int          ph = 0, m_way = 0, m_idx = 0, m_off = 0, m_beats = 0;
    bit          m_err = 0, e_valid = 0, e_known = 1;
    logic [31:0] e_data = 0;

    always @(posedge clk) if (resetn) begin : model
        bit rdy;
        int w;
        rdy = !(ph != 0 && int'(rd_index) == m_idx);
        if (rd_en && rdy) begin
            e_valid = 1;
            if (rd_hit_way == 0) begin
                e_data = 0;
                e_known = 1;
            end else begin
                w = rd_hit_way[1] ? 1 : 0;
                e_data = m_mem[w][rd_index][rd_offset];
                e_known = m_known[w][rd_index][rd_offset];
            end
        end else e_valid = 0;
        if (ph == 2) ph = 0;
        else if (ph == 1 && refill_valid) begin
            if (m_beats < 8) begin
                m_mem[m_way][m_idx][(m_off + m_beats) % 8] = refill_data;
                m_known[m_way][m_idx][(m_off + m_beats) % 8] = 1;
            end
            m_beats++;
            if (refill_last) begin
                ph = 2;
                m_err = m_beats != 8;
            end
        end else if (ph == 0 && refill_start) begin
            ph = 1;
            m_way = int'(refill_way);
            m_idx = int'(refill_index);
            m_off = int'(refill_offset);
            m_beats = 0;
        end
    end

    always @(negedge resetn) begin
        if (ph != 0) for (int i = 0; i < 8; i++) m_known[m_way][m_idx][i] = 0;
        ph = 0;
        e_valid = 0;
        e_data = 0;
        e_known = 1;
    end

    always @(negedge clk) if (resetn && started) begin
        chk("rd_valid", rd_valid, e_valid);
        chk("rd_ready", rd_ready, !(ph != 0 && int'(rd_index) == m_idx));
        chk("refill_busy", refill_busy, ph != 0);
        chk("refill_done", refill_done, ph == 2);
        chk("refill_err", refill_err, ph == 2 && m_err);
        if (e_known) chk("rd_data", rd_data, e_data);
    end

    always @(posedge clk) if (rd_en && !$onehot0(rd_hit_way)) $error("multi-hot rd_hit_way driven");

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic refill(int w, int idx, int off, int n, logic [31:0] base, int last_at,
                          bit rd_mix, bit restart, bit exp_err);
        refill_way = 1'(w);
        refill_index = 7'(idx);
        refill_offset = 3'(off);
        refill_start = 1;
        tick();
        refill_start = 0;
        for (int i = 0; i < n; i++) begin
            refill_valid = 1;
            refill_data = base + 32'(i);
            refill_last = (i + 1 == last_at);
            if (rd_mix) begin
                rd_en = 1;
                rd_index = (i % 2 == 1) ? 7'd9 : 7'(idx);
                rd_offset = 3'(i);
                rd_hit_way = 2'b01;
            end
            if (restart && i == 2) begin
                refill_start = 1;
                refill_index = 7'd77;
                refill_way = 0;
            end
            tick();
            refill_start = 0;
        end
        refill_valid = 0;
        refill_last = 0;
        rd_en = 0;
        chk("lit_done", refill_done, 1);
        chk("lit_err", refill_err, 32'(exp_err));
        tick();
        chk("lit_busy_fall", refill_busy, 0);
        tick();
    endtask

    task automatic readline(int w, int idx);
        for (int o = 0; o < 8; o++) begin
            rd_en = 1;
            rd_index = 7'(idx);
            rd_offset = 3'(o);
            rd_hit_way = 2'(1 << w);
            tick();
        end
        rd_en = 0;
        tick();
    endtask

    task automatic rd_lit(logic [1:0] hit, int idx, int off, logic [31:0] exp);
        rd_en = 1;
        rd_index = 7'(idx);
        rd_offset = 3'(off);
        rd_hit_way = hit;
        tick();
        rd_en = 0;
        chk("lit_rd_valid", rd_valid, 1);
        chk("lit_rd_data", rd_data, exp);
    endtask

    initial begin
        repeat (2) tick();
        chk("reset_ready", rd_ready, 1);
        chk("reset_data", rd_data, 0);
        resetn = 1;
        started = 1;
        tick();
        rd_en = 1;
        rd_index = 0;
        rd_offset = 0;
        rd_hit_way = 2'b01;
        tick();
        rd_en = 0;
        chk("first_rd_valid", rd_valid, 1);
        chk("first_rd_ready", rd_ready, 1);
        tick();
        chk("valid_drop", rd_valid, 0);

        refill(0, 9, 0, 8, 32'h900, 8, 0, 0, 0);
        readline(0, 9);
        refill(1, 5, 6, 8, 32'hA0, 8, 1, 1, 0);
        chk("model_w6", m_mem[1][5][6], 32'hA0);
        chk("model_w5", m_mem[1][5][5], 32'hA7);
        readline(1, 5);
        rd_lit(2'b10, 5, 6, 32'hA0);
        rd_lit(2'b10, 5, 0, 32'hA2);
        rd_lit(2'b10, 5, 5, 32'hA7);
        rd_lit(2'b01, 9, 3, 32'h903);
        rd_lit(2'b00, 5, 6, 32'h0);

        refill(1, 40, 1, 5, 32'hC0, 5, 0, 0, 1);
        refill(0, 30, 0, 10, 32'hB0, 10, 0, 0, 1);
        rd_lit(2'b01, 30, 7, 32'hB7);
        rd_lit(2'b01, 30, 0, 32'hB0);

        refill_way = 0;
        refill_index = 20;
        refill_offset = 2;
        refill_start = 1;
        tick();
        refill_start = 0;
        for (int i = 0; i < 3; i++) begin
            refill_valid = 1;
            refill_data = 32'hE0 + 32'(i);
            rd_en = (i == 1);
            rd_index = 9;
            rd_hit_way = 2'b01;
            if (i < 2) tick();
        end
        rd_en = 0;
        chk("pre_reset_busy", refill_busy, 1);
        chk("pre_reset_valid", rd_valid, 1);
        #1 resetn = 0;
        #1;
        chk("async_busy", refill_busy, 0);
        chk("async_done", refill_done, 0);
        chk("async_valid", rd_valid, 0);
        chk("async_ready", rd_ready, 1);
        refill_valid = 0;
        tick();
        tick();
        resetn = 1;
        tick();
        refill(0, 20, 3, 8, 32'hD0, 8, 0, 0, 0);
        readline(0, 20);
        rd_lit(2'b01, 20, 3, 32'hD0);
        rd_lit(2'b01, 20, 2, 32'hD7);
        tick();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/icache_data_array.md
# icache_data_array

Parametrised instruction-cache data store: WAYS ways × 2^INDEX_W sets × LINE_WORDS words of DATA_W bits, with a synchronous one-cycle read port and a burst refill engine that writes a full line in wrapped, critical-word-first order. Sits between the tag/hit logic of the fetch stage and the AXI read channel of the bus interface. Supersedes the single-way, word-enable data RAM.

## Interface
- WAYS, 2, number of ways (1..8)
- INDEX_W, 7, set index width
- LINE_WORDS, 8, words per line (power of two, ≥2); OFF_W = log2(LINE_WORDS)
- DATA_W, 32, word width
- clk  in  1  single clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- rd_en  in  1  read request; accepted when rd_en && rd_ready
- rd_ready  out  1  read port can accept this cycle
- rd_index  in  INDEX_W  set of read
- rd_offset  in  OFF_W  word within line
- rd_hit_way  in  WAYS  one-hot way select from tag compare, sampled with the request
- rd_valid  out  1  rd_data valid this cycle
- rd_data  out  DATA_W  selected word
- refill_start  in  1  begin refill (accepted only in IDLE)
- refill_way  in  log2(WAYS) (min 1)  victim way
- refill_index  in  INDEX_W  set being refilled
- refill_offset  in  OFF_W  offset of first beat (critical word)
- refill_valid  in  1  data beat present
- refill_data  in  DATA_W  beat data
- refill_last  in  1  final beat marker
- refill_busy  out  1  refill in progress
- refill_done  out  1  one-cycle pulse after final beat written
- refill_err  out  1  one-cycle pulse with refill_done when beat count ≠ LINE_WORDS

## Operation
- Storage: one array per way, synchronous write, synchronous read; contents not reset.
- Read: on accept, word [way][rd_index][rd_offset] is output next cycle, muxed by registered rd_hit_way. rd_hit_way = 0 → rd_data = 0, rd_valid still 1. Multi-hot rd_hit_way is illegal (bench asserts never driven).
- rd_ready = 0 when refill_busy and rd_index == latched refill index (any way); otherwise 1. Reads to other sets proceed concurrently with refill writes.
- Refill FSM: IDLE → FILL on refill_start (latch way, index, offset; ptr ← refill_offset, beat count ← 0). refill_start in FILL/DONE ignored.
- FILL: each refill_valid writes refill_data to [way][index][ptr]; ptr ← ptr+1 mod LINE_WORDS (wraps LINE_WORDS-1 → 0); count increments, saturating at LINE_WORDS. Beats after count = LINE_WORDS are dropped (no write). refill_valid && refill_last → DONE.
- DONE: refill_done = 1 for one cycle; refill_err = 1 if total beats received (including last) ≠ LINE_WORDS; → IDLE. refill_busy = 1 in FILL and DONE.
- refill_valid in IDLE ignored.
- Reset mid-refill: FSM → IDLE immediately; partially written line undefined; tag valid owned by caller, which must not set it without refill_done.

## Timing
- Reset values: rd_valid 0, rd_data 0, refill_busy 0, refill_done 0, refill_err 0, rd_ready 1, FSM IDLE, ptr 0, count 0.
- Read latency 1: accept at edge N → rd_valid/rd_data at N+1; back-to-back reads every cycle.
- rd_valid deasserts the cycle after no accept; rd_data holds last value.
- refill_start at edge N: first beat may arrive at N+1 (not in the same cycle as start).
- Beat written at edge N is readable by a read accepted at N+1 or later (other sets), and by the refilled set from the cycle after refill_done (rd_ready rises when FSM returns to IDLE).
- Write/read same array same cycle, different set: both complete; same set impossible by rd_ready rule.
- refill_done at cycle after last-beat edge; refill_busy falls one cycle later.

## Test plan
- Reset then read way0 set 0 offset 0 with rd_hit_way=01 → rd_valid=1 next cycle, no X on control outputs; rd_ready=1 throughout.
- Refill way1 set 5 offset 6, beats 0xA0..0xA7 (LINE_WORDS=8) → words 6,7,0..5 = A0..A7; refill_done pulse, refill_err=0; subsequent reads of all 8 offsets return expected data, 1-cycle latency.
- During refill of set 5, read set 5 → rd_ready=0 until FSM IDLE; concurrent read set 9 returns pre-loaded data unchanged.
- refill_last on beat 5 → refill_done and refill_err=1; 10 beats with last on 10th → words 0..7 from first 8 beats, beats 9–10 dropped, refill_err=1.
- Read with rd_hit_way=00 → rd_data=0, rd_valid=1; refill_start while busy ignored (latched index unchanged).
- Assert resetn low on 3rd refill beat → busy/done/valid drop asynchronously; new refill after release completes correctly.
